// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the control-register sequencer.
// READBACK_CHECK_EN selects the optional write-verify pass in the top level.
package ctrl_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READBACK,
      S_BEGIN,
      S_WAIT_ACK,
      S_WAIT_CMP,
      S_DONE
   } state_e;

   localparam logic [1:0] REG_OFFSET = 2'd0;
   localparam logic [1:0] REG_DEST   = 2'd1;
   localparam logic [1:0] REG_NUMOPS = 2'd2;
   localparam logic [1:0] REG_ROUTER = 2'd3;

   localparam int RTR_WRITE_REVERSE  = 6;
   localparam int RTR_ACT_FUNC_HI    = 5;
   localparam int RTR_ACT_FUNC_LO    = 4;
   localparam int RTR_CACHE_SEL_HI   = 3;
   localparam int RTR_CACHE_SEL_LO   = 2;
   localparam int RTR_WEIGHT_NOT_IDX = 1;
   localparam int RTR_PARAM_NOT_LYR  = 0;

   function automatic logic [15:0] router_word(input logic [6:0] rtr);
      return {9'd0, rtr};
   endfunction

endpackage

// File: rtl/ctrl_seq_watchdog.sv
// Load/count/expire counter bounding the sequencer's handshake wait states.
// TIMEOUT_CYCLES of 0 disables expiry.
module ctrl_seq_watchdog #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);

   logic [15:0] cnt_q, cnt_d, cnt_inc;

   assign cnt_inc = cnt_q + 16'd1;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)    cnt_d = '0;
      else if (en_i) cnt_d = cnt_inc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // Fires on the cycle the count would reach the limit, so the FSM leaves
   // after exactly TIMEOUT_CYCLES cycles in a wait state.
   assign expired_o = en_i && !load_i && (TIMEOUT_CYCLES != 16'd0) &&
                      (cnt_inc == TIMEOUT_CYCLES);

endmodule

// File: rtl/control_reg_sequencer.sv
// Writes one layer command into the control-register block, starts the op and
// tracks its handshake. Define READBACK_CHECK_EN to verify writes before beginOp.
module control_reg_sequencer
   import ctrl_seq_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR      = 16'h8000,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmdValid,
   output logic        cmdReady,
   input  logic [15:0] cmdOffset,
   input  logic [15:0] cmdDest,
   input  logic [15:0] cmdNumOps,
   input  logic [6:0]  cmdRouter,
   output logic        WE,
   output logic [15:0] regAddr,
   output logic [15:0] regWData,
   input  logic [15:0] regRData,
   output logic        beginOp,
   input  logic        readyForNextOp,
   output logic        done,
   output logic        busy,
   output logic        timeout,
   output logic        rbError
);

   state_e            state_q;
   logic [1:0]        idx_q;
   logic [3:0][15:0]  pay_q;
   logic              cmd_ready_q, we_q, begin_q, done_q, busy_q, timeout_q;
   logic [15:0]       addr_q, wdata_q;
   logic [1:0]        idx_nxt;
   logic [15:0]       addr_nxt;
   logic              wd_load, wd_en, wd_expired;

   assign idx_nxt  = idx_q + 2'd1;
   assign addr_nxt = BASE_ADDR + {14'd0, idx_nxt};

   // Counter restarts on every entry into a wait state.
   assign wd_load = (state_q == S_BEGIN) ||
                    (state_q == S_WAIT_ACK && !readyForNextOp);
   assign wd_en   = (state_q == S_WAIT_ACK) || (state_q == S_WAIT_CMP);

   ctrl_seq_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .load_i    (wd_load),
      .en_i      (wd_en),
      .expired_o (wd_expired)
   );

`ifdef READBACK_CHECK_EN
   logic rb_err_q;
   logic rb_mismatch;
   assign rb_mismatch = (regRData != pay_q[idx_q]);
   assign rbError     = rb_err_q;
`else
   logic unused_rdata;
   assign unused_rdata = ^regRData;
   assign rbError      = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         pay_q       <= '0;
         cmd_ready_q <= 1'b1;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         begin_q     <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         timeout_q   <= 1'b0;
`ifdef READBACK_CHECK_EN
         rb_err_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cmdValid) begin
                  pay_q       <= {router_word(cmdRouter), cmdNumOps, cmdDest, cmdOffset};
                  idx_q       <= REG_OFFSET;
                  timeout_q   <= 1'b0;
`ifdef READBACK_CHECK_EN
                  rb_err_q    <= 1'b0;
`endif
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  we_q        <= 1'b1;
                  addr_q      <= BASE_ADDR;
                  wdata_q     <= cmdOffset;
                  state_q     <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (idx_q == REG_ROUTER) begin
                  we_q    <= 1'b0;
                  wdata_q <= '0;
                  idx_q   <= '0;
`ifdef READBACK_CHECK_EN
                  addr_q  <= BASE_ADDR;
                  state_q <= S_READBACK;
`else
                  addr_q  <= '0;
                  begin_q <= 1'b1;
                  state_q <= S_BEGIN;
`endif
               end else begin
                  idx_q   <= idx_nxt;
                  addr_q  <= addr_nxt;
                  wdata_q <= pay_q[idx_nxt];
               end
            end
`ifdef READBACK_CHECK_EN
            S_READBACK: begin
               // Read data is combinational, so it matches addr_q this cycle.
               if (rb_mismatch) begin
                  rb_err_q <= 1'b1;
                  addr_q   <= '0;
                  idx_q    <= '0;
                  done_q   <= 1'b1;
                  state_q  <= S_DONE;
               end else if (idx_q == REG_ROUTER) begin
                  addr_q  <= '0;
                  idx_q   <= '0;
                  begin_q <= 1'b1;
                  state_q <= S_BEGIN;
               end else begin
                  idx_q  <= idx_nxt;
                  addr_q <= addr_nxt;
               end
            end
`endif
            S_BEGIN: begin
               begin_q <= 1'b0;
               state_q <= S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               if (!readyForNextOp) begin
                  state_q <= S_WAIT_CMP;
               end else if (wd_expired) begin
                  timeout_q <= 1'b1;
                  done_q    <= 1'b1;
                  state_q   <= S_DONE;
               end
            end
            S_WAIT_CMP: begin
               if (readyForNextOp) begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else if (wd_expired) begin
                  timeout_q <= 1'b1;
                  done_q    <= 1'b1;
                  state_q   <= S_DONE;
               end
            end
            S_DONE: begin
               done_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cmdReady = cmd_ready_q;
   assign WE       = we_q;
   assign regAddr  = addr_q;
   assign regWData = wdata_q;
   assign beginOp  = begin_q;
   assign done     = done_q;
   assign busy     = busy_q;
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_control_reg_sequencer.sv
// Directed bench: dut_a has an 8-cycle watchdog, dut_b has the watchdog disabled.
`timescale 1ns/1ps
module tb_control_reg_sequencer;

`ifdef READBACK_CHECK_EN
   localparam int RB = 4;
`else
   localparam int RB = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [15:0] offset, dest, numops;
   logic [6:0]  router;

   logic        valid_a, rdy_a, cready_a, we_a, beg_a, done_a, busy_a, to_a, rbe_a;
   logic [15:0] addr_a, wd_a, rd_a;
   logic        valid_b, rdy_b, cready_b, we_b, beg_b, done_b, busy_b, to_b, rbe_b;
   logic [15:0] addr_b, wd_b, rd_b;

   int total = 0;
   int bad   = 0;

   control_reg_sequencer #(.BASE_ADDR(16'h8000), .TIMEOUT_CYCLES(16'd8)) dut_a (
      .clk(clk), .rst(rst), .cmdValid(valid_a), .cmdReady(cready_a),
      .cmdOffset(offset), .cmdDest(dest), .cmdNumOps(numops), .cmdRouter(router),
      .WE(we_a), .regAddr(addr_a), .regWData(wd_a), .regRData(rd_a),
      .beginOp(beg_a), .readyForNextOp(rdy_a), .done(done_a), .busy(busy_a),
      .timeout(to_a), .rbError(rbe_a)
   );

   control_reg_sequencer #(.BASE_ADDR(16'h8000), .TIMEOUT_CYCLES(16'd0)) dut_b (
      .clk(clk), .rst(rst), .cmdValid(valid_b), .cmdReady(cready_b),
      .cmdOffset(offset), .cmdDest(dest), .cmdNumOps(numops), .cmdRouter(router),
      .WE(we_b), .regAddr(addr_b), .regWData(wd_b), .regRData(rd_b),
      .beginOp(beg_b), .readyForNextOp(rdy_b), .done(done_b), .busy(busy_b),
      .timeout(to_b), .rbError(rbe_b)
   );

   // Control-register block models; corrupt_a flips bit 0 of the dest register.
   logic [15:0] regs_a [4];
   logic [15:0] regs_b [4];
   logic        corrupt_a = 1'b0;

   always @(posedge clk) begin
      if (we_a && addr_a[15:2] == 14'h2000)
         regs_a[addr_a[1:0]] <= (corrupt_a && addr_a[1:0] == 2'd1) ? (wd_a ^ 16'h0001) : wd_a;
      if (we_b && addr_b[15:2] == 14'h2000)
         regs_b[addr_b[1:0]] <= wd_b;
   end
   assign rd_a = (addr_a[15:2] == 14'h2000) ? regs_a[addr_a[1:0]] : 16'h0000;
   assign rd_b = (addr_b[15:2] == 14'h2000) ? regs_b[addr_b[1:0]] : 16'h0000;

   logic [15:0] exp_w [4];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd;
      offset = 16'h0010; dest = 16'h0200; numops = 16'h0005; router = 7'h35;
      exp_w[0] = 16'h0010; exp_w[1] = 16'h0200; exp_w[2] = 16'h0005; exp_w[3] = 16'h0035;
   endtask

   task automatic test_reset;
      logic [38:0] got;
      rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1;
      set_cmd();
      #12;
      got = {cready_a, we_a, beg_a, done_a, busy_a, to_a, rbe_a, addr_a, wd_a};
      total++;
      if (got !== {1'b1, 6'b0, 32'h0}) begin
         bad++; $display("FAIL reset_a_held got=%h exp=%h", got, {1'b1, 6'b0, 32'h0});
      end
      rst = 1'b0;
      tick();
      got = {cready_a, we_a, beg_a, done_a, busy_a, to_a, rbe_a, addr_a, wd_a};
      total++;
      if (got !== {1'b1, 6'b0, 32'h0}) begin
         bad++; $display("FAIL reset_a_idle got=%h exp=%h", got, {1'b1, 6'b0, 32'h0});
      end
      got = {cready_b, we_b, beg_b, done_b, busy_b, to_b, rbe_b, addr_b, wd_b};
      total++;
      if (got !== {1'b1, 6'b0, 32'h0}) begin
         bad++; $display("FAIL reset_b_idle got=%h exp=%h", got, {1'b1, 6'b0, 32'h0});
      end
   endtask

   // Ready drops 2 cycles after beginOp and rises 3 cycles later.
   task automatic test_nominal;
      logic [34:0] got, exp;
      logic [15:0] ea, ew;
      set_cmd();
      valid_a = 1'b1;
      for (int c = 1; c <= 12 + RB; c++) begin
         tick();
         if (c == 1) begin
            valid_a = 1'b0;
            offset = 16'hdead; dest = 16'hbeef; numops = 16'h1234; router = 7'h7f;
         end
         rdy_a = !(c >= 7 + RB && c < 10 + RB);
         ea = 16'h0; ew = 16'h0;
         if (c >= 1 && c <= 4) begin
            ea = 16'h8000 + 16'(c - 1); ew = exp_w[c - 1];
         end else if (RB != 0 && c >= 5 && c <= 8) begin
            ea = 16'h8000 + 16'(c - 5);
         end
         exp = {(c >= 1 && c <= 4), (c == 5 + RB), (c == 11 + RB), ea, ew};
         got = {we_a, beg_a, done_a, addr_a, wd_a};
         total++;
         if (got !== exp) begin
            bad++; $display("FAIL nominal c=%0d got=%h exp=%h", c, got, exp);
         end
      end
      got = {32'h0, cready_a, to_a, rbe_a};
      total++;
      if (got !== {32'h0, 3'b100}) begin
         bad++; $display("FAIL nominal_flags got=%h exp=%h", got, {32'h0, 3'b100});
      end
   endtask

   task automatic test_readback;
      logic [3:0] got, exp;
      set_cmd();
      corrupt_a = 1'b1;
      valid_a = 1'b1;
`ifdef READBACK_CHECK_EN
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 1) valid_a = 1'b0;
         exp = {1'b0, (c == 7), (c >= 7), (c == 8)};
         got = {beg_a, done_a, rbe_a, cready_a};
         total++;
         if (got !== exp) begin
            bad++; $display("FAIL readback c=%0d got=%b exp=%b", c, got, exp);
         end
      end
`else
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (c == 1) valid_a = 1'b0;
         rdy_a = (c != 6);
         exp = {(c == 5), (c == 8), 1'b0, (c == 9)};
         got = {beg_a, done_a, rbe_a, cready_a};
         total++;
         if (got !== exp) begin
            bad++; $display("FAIL readback_off c=%0d got=%b exp=%b", c, got, exp);
         end
      end
`endif
      corrupt_a = 1'b0;
      rdy_a = 1'b1;
   endtask

   task automatic test_timeout;
      logic [4:0] got, exp;
      set_cmd();
      rdy_a = 1'b1;
      valid_a = 1'b1;
      for (int c = 1; c <= 15 + RB; c++) begin
         tick();
         if (c == 1) valid_a = 1'b0;
         if (c == 5 + RB || c >= 13 + RB) begin
            exp = {(c == 5 + RB), (c == 14 + RB), (c >= 14 + RB), (c == 15 + RB), (c < 15 + RB)};
            got = {beg_a, done_a, to_a, cready_a, busy_a};
            total++;
            if (got !== exp) begin
               bad++; $display("FAIL timeout c=%0d got=%b exp=%b", c, got, exp);
            end
         end
      end
      // Next accept clears the flag; minimum-latency handshake.
      valid_a = 1'b1;
      for (int c = 1; c <= 9 + RB; c++) begin
         tick();
         if (c == 1) begin
            valid_a = 1'b0;
            total++;
            if (to_a !== 1'b0) begin
               bad++; $display("FAIL timeout_clear got=%b exp=0", to_a);
            end
         end
         rdy_a = (c != 6 + RB);
         if (c >= 7 + RB) begin
            exp = {1'b0, (c == 8 + RB), 1'b0, (c == 9 + RB), (c != 9 + RB)};
            got = {beg_a, done_a, to_a, cready_a, busy_a};
            total++;
            if (got !== exp) begin
               bad++; $display("FAIL min_latency c=%0d got=%b exp=%b", c, got, exp);
            end
         end
      end
      rdy_a = 1'b1;
   endtask

   task automatic test_reset_mid;
      logic [38:0] got;
      set_cmd();
      valid_a = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         tick();
         if (c == 1) valid_a = 1'b0;
      end
      total++;
      if ({we_a, addr_a, wd_a} !== {1'b1, 16'h8002, 16'h0005}) begin
         bad++; $display("FAIL reset_mid_pre got=%h exp=%h", {we_a, addr_a, wd_a}, {1'b1, 16'h8002, 16'h0005});
      end
      rst = 1'b1;
      #1;
      got = {cready_a, we_a, beg_a, done_a, busy_a, to_a, rbe_a, addr_a, wd_a};
      total++;
      if (got !== {1'b1, 6'b0, 32'h0}) begin
         bad++; $display("FAIL reset_mid_async got=%h exp=%h", got, {1'b1, 6'b0, 32'h0});
      end
      rst = 1'b0;
      #1;
      valid_a = 1'b1;
      for (int c = 1; c <= 9 + RB; c++) begin
         tick();
         if (c == 1) begin
            valid_a = 1'b0;
            total++;
            if ({we_a, addr_a, wd_a} !== {1'b1, 16'h8000, 16'h0010}) begin
               bad++; $display("FAIL reset_mid_restart got=%h exp=%h", {we_a, addr_a, wd_a}, {1'b1, 16'h8000, 16'h0010});
            end
         end
         rdy_a = (c != 6 + RB);
         if (c == 8 + RB || c == 9 + RB) begin
            total++;
            if ({done_a, cready_a} !== {(c == 8 + RB), (c == 9 + RB)}) begin
               bad++; $display("FAIL reset_mid_done c=%0d got=%b exp=%b", c, {done_a, cready_a}, {(c == 8 + RB), (c == 9 + RB)});
            end
         end
      end
      rdy_a = 1'b1;
   endtask

   task automatic test_back_to_back;
      int acc = 0;
      int dn  = 0;
      int acc_cyc [3];
      int dn_cyc  [3];
      logic prev_beg = 1'b0;
      int P = 9 + RB;
      set_cmd();
      valid_a = 1'b1;
      for (int c = 0; c < 45; c++) begin
         rdy_a = !prev_beg;
         if (valid_a && cready_a) begin
            total++;
            if (busy_a !== 1'b0 || done_a !== 1'b0) begin
               bad++; $display("FAIL b2b_accept_state c=%0d busy=%b done=%b exp=00", c, busy_a, done_a);
            end
            if (acc < 3) acc_cyc[acc] = c;
            acc++;
         end
         if (done_a) begin
            total++;
            if (cready_a !== 1'b0) begin
               bad++; $display("FAIL b2b_ready_in_done c=%0d got=%b exp=0", c, cready_a);
            end
            if (dn < 3) dn_cyc[dn] = c;
            dn++;
         end
         prev_beg = beg_a;
         tick();
         if (acc >= 3) valid_a = 1'b0;
      end
      total++;
      if (acc != 3 || dn != 3) begin
         bad++; $display("FAIL b2b_counts accepts=%0d dones=%0d exp=3/3", acc, dn);
      end
      for (int k = 0; k < 3; k++) begin
         if (k < acc && k < dn) begin
            total++;
            if (acc_cyc[k] != k * P || dn_cyc[k] != (k + 1) * P - 1) begin
               bad++; $display("FAIL b2b_cycle k=%0d got=%0d/%0d exp=%0d/%0d", k, acc_cyc[k], dn_cyc[k], k * P, (k + 1) * P - 1);
            end
         end
      end
      rdy_a = 1'b1;
   endtask

   task automatic test_no_watchdog;
      logic seen_to = 1'b0;
      logic seen_dn = 1'b0;
      set_cmd();
      valid_b = 1'b1;
      rdy_b   = 1'b0;
      for (int c = 1; c <= 10000; c++) begin
         tick();
         if (c == 1) valid_b = 1'b0;
         if (to_b) seen_to = 1'b1;
         if (done_b) seen_dn = 1'b1;
         if (c == 5 + RB) begin
            total++;
            if (beg_b !== 1'b1) begin
               bad++; $display("FAIL nowd_begin got=%b exp=1", beg_b);
            end
         end
      end
      total++;
      if ({seen_to, seen_dn, busy_b} !== 3'b001) begin
         bad++; $display("FAIL nowd_hold got=%b exp=001", {seen_to, seen_dn, busy_b});
      end
      rdy_b = 1'b1;
      tick();
      total++;
      if ({done_b, to_b, cready_b} !== 3'b100) begin
         bad++; $display("FAIL nowd_done got=%b exp=100", {done_b, to_b, cready_b});
      end
      tick();
      total++;
      if ({done_b, cready_b} !== 2'b01) begin
         bad++; $display("FAIL nowd_idle got=%b exp=01", {done_b, cready_b});
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_readback();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_no_watchdog();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
